// File: rtl/perf_event_counter.sv
// Run-window performance monitor: one cycle counter plus NUM_EVT event counters,
// with an auto-stop window, saturate/wrap overflow, an atomic snapshot and a registered read-back mux.
module perf_event_counter #(
    parameter int unsigned NUM_EVT    = 2,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned MAX_CYCLES = 30,
    parameter int unsigned SATURATE   = 1,
    localparam int unsigned SEL_W     = $clog2(NUM_EVT + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic               clr_i,
    input  logic               snap_i,
    input  logic [SEL_W-1:0]   rd_sel_i,
    output logic [CNT_W-1:0]   rd_data_o,
    output logic [CNT_W-1:0]   cycle_o,
    output logic               running_o,
    output logic               done_o,
    output logic [NUM_EVT:0]   ovf_o
);

    localparam int unsigned NUM_CNT = NUM_EVT + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;

    // Index 0 is the cycle counter, index k is event channel k-1.
    logic [CNT_W-1:0]   live     [NUM_CNT];
    logic [CNT_W-1:0]   live_nxt [NUM_CNT];
    logic [CNT_W-1:0]   shadow   [NUM_CNT];
    logic [NUM_EVT:0]   ovf_nxt;
    logic [NUM_EVT:0]   hit;
    logic [CNT_W-1:0]   rd_mux;

    assign hit     = {evt_i, 1'b1};
    assign cycle_o = live[0];

    // Per-counter increment with sticky overflow; only active while running.
    always_comb begin
        ovf_nxt = ovf_o;
        for (int unsigned k = 0; k < NUM_CNT; k++) begin
            live_nxt[k] = live[k];
            if (state == RUN && hit[k]) begin
                if (live[k] == {CNT_W{1'b1}}) begin
                    ovf_nxt[k]  = 1'b1;
                    live_nxt[k] = (SATURATE != 0) ? live[k] : '0;
                end else begin
                    live_nxt[k] = live[k] + CNT_W'(1);
                end
            end
        end
    end

    // Next-state logic; clear overrides everything else.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start_i) next_state = RUN;
            RUN: begin
                if (MAX_CYCLES != 0 && live_nxt[0] == CNT_W'(MAX_CYCLES))
                    next_state = DONE;
            end
            DONE:    next_state = DONE;
            default: next_state = IDLE;
        endcase
        if (clr_i) next_state = IDLE;
    end

    // Out-of-range selects read as zero.
    always_comb begin
        rd_mux = '0;
        for (int unsigned k = 0; k < NUM_CNT; k++) begin
            if (rd_sel_i == SEL_W'(k)) rd_mux = shadow[k];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            running_o <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            state     <= next_state;
            running_o <= (next_state == RUN);
            done_o    <= (next_state == DONE);
        end
    end

    // Snapshot samples the pre-edge live values, so it sees pre-clear values too.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int unsigned k = 0; k < NUM_CNT; k++) begin
                live[k]   <= '0;
                shadow[k] <= '0;
            end
            ovf_o     <= '0;
            rd_data_o <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_CNT; k++) begin
                live[k] <= clr_i ? '0 : live_nxt[k];
                if (snap_i) shadow[k] <= live[k];
            end
            ovf_o     <= clr_i ? '0 : ovf_nxt;
            rd_data_o <= rd_mux;
        end
    end

endmodule

// File: tb/tb_perf_event_counter.sv
// Directed bench for perf_event_counter: a vector table on the default configuration
// plus hand sequences for 4-bit saturate/wrap overflow.
module tb_perf_event_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default configuration under table control.
    logic        m_rst = 1'b0, m_start = 1'b0, m_clr = 1'b0, m_snap = 1'b0;
    logic [1:0]  m_evt = '0, m_sel = '0;
    logic [31:0] m_rd, m_cycle;
    logic        m_run, m_done;
    logic [2:0]  m_ovf;

    perf_event_counter dut (
        .clk_i(clk), .rst_i(m_rst), .start_i(m_start), .evt_i(m_evt), .clr_i(m_clr),
        .snap_i(m_snap), .rd_sel_i(m_sel), .rd_data_o(m_rd), .cycle_o(m_cycle),
        .running_o(m_run), .done_o(m_done), .ovf_o(m_ovf)
    );

    // 4-bit, unlimited window, saturating and wrapping variants sharing stimulus.
    logic       t_rst = 1'b0, t_start = 1'b0, t_clr = 1'b0, t_snap = 1'b0;
    logic [1:0] t_evt = '0, t_sel = '0;
    logic [3:0] s_rd, s_cycle, w_rd, w_cycle;
    logic       s_run, s_done, w_run, w_done;
    logic [2:0] s_ovf, w_ovf;

    perf_event_counter #(.CNT_W(4), .MAX_CYCLES(0), .SATURATE(1)) dut_sat (
        .clk_i(clk), .rst_i(t_rst), .start_i(t_start), .evt_i(t_evt), .clr_i(t_clr),
        .snap_i(t_snap), .rd_sel_i(t_sel), .rd_data_o(s_rd), .cycle_o(s_cycle),
        .running_o(s_run), .done_o(s_done), .ovf_o(s_ovf)
    );

    perf_event_counter #(.CNT_W(4), .MAX_CYCLES(0), .SATURATE(0)) dut_wrap (
        .clk_i(clk), .rst_i(t_rst), .start_i(t_start), .evt_i(t_evt), .clr_i(t_clr),
        .snap_i(t_snap), .rd_sel_i(t_sel), .rd_data_o(w_rd), .cycle_o(w_cycle),
        .running_o(w_run), .done_o(w_done), .ovf_o(w_ovf)
    );

    typedef struct {
        logic        rst, start;
        logic [1:0]  evt;
        logic        clr, snap;
        logic [1:0]  sel;
        int          n;
        logic [31:0] cyc;
        logic        run, done;
        logic [31:0] rd;
        logic [2:0]  ovf;
    } vec_t;

    vec_t tbl[$];
    int   vecs = 0;
    int   errs = 0;

    function automatic vec_t v(input logic rst, input logic start, input logic [1:0] evt,
                               input logic clr, input logic snap, input logic [1:0] sel,
                               input int n, input logic [31:0] cyc, input logic run,
                               input logic done, input logic [31:0] rd, input logic [2:0] ovf);
        vec_t r;
        r.rst = rst; r.start = start; r.evt = evt; r.clr = clr; r.snap = snap; r.sel = sel;
        r.n = n; r.cyc = cyc; r.run = run; r.done = done; r.rd = rd; r.ovf = ovf;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic t_edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        //             rst st evt  clr sn sel  n   cyc run dn  rd  ovf
        tbl.push_back(v(0, 0, 2'b00, 0, 0, 0,  1,  0, 0, 0,  0, 0)); // reset state
        tbl.push_back(v(1, 1, 2'b00, 0, 0, 0,  1,  0, 1, 0,  0, 0)); // start edge: no count
        tbl.push_back(v(1, 0, 2'b01, 0, 0, 0, 29, 29, 1, 0,  0, 0));
        tbl.push_back(v(1, 0, 2'b01, 0, 0, 0,  1, 30, 0, 1,  0, 0)); // window ends at 30
        tbl.push_back(v(1, 1, 2'b01, 0, 0, 0, 10, 30, 0, 1,  0, 0)); // frozen, start ignored
        tbl.push_back(v(1, 0, 2'b01, 0, 1, 1,  1, 30, 0, 1,  0, 0)); // snap; rd lags
        tbl.push_back(v(1, 0, 2'b00, 0, 0, 1,  1, 30, 0, 1, 30, 0)); // evt0 = 30
        tbl.push_back(v(1, 0, 2'b00, 0, 0, 2,  1, 30, 0, 1,  0, 0)); // evt1 = 0
        tbl.push_back(v(1, 0, 2'b00, 0, 0, 0,  1, 30, 0, 1, 30, 0)); // cycle = 30
        tbl.push_back(v(1, 0, 2'b00, 0, 0, 3,  1, 30, 0, 1,  0, 0)); // out-of-range sel
        tbl.push_back(v(1, 1, 2'b11, 1, 0, 0,  1,  0, 0, 0, 30, 0)); // clr beats start
        tbl.push_back(v(1, 1, 2'b00, 0, 0, 0,  1,  0, 1, 0, 30, 0));
        tbl.push_back(v(1, 0, 2'b00, 0, 0, 0,  2,  2, 1, 0, 30, 0));
        tbl.push_back(v(1, 0, 2'b10, 0, 0, 0,  3,  5, 1, 0, 30, 0)); // evt1 on cycles 3..5
        tbl.push_back(v(1, 0, 2'b00, 0, 0, 0,  5, 10, 1, 0, 30, 0));
        tbl.push_back(v(1, 0, 2'b00, 0, 1, 2,  1, 11, 1, 0,  0, 0)); // snap at cycle 10
        tbl.push_back(v(1, 0, 2'b00, 0, 0, 2,  1, 12, 1, 0,  3, 0));
        tbl.push_back(v(1, 0, 2'b00, 0, 0, 0,  1, 13, 1, 0, 10, 0));
        tbl.push_back(v(1, 0, 2'b00, 1, 0, 0,  1,  0, 0, 0, 10, 0));
        tbl.push_back(v(1, 1, 2'b00, 0, 0, 0,  1,  0, 1, 0, 10, 0));
        tbl.push_back(v(1, 0, 2'b00, 0, 0, 0, 12, 12, 1, 0, 10, 0));
        tbl.push_back(v(1, 0, 2'b00, 1, 1, 0,  1,  0, 0, 0, 10, 0)); // clr+snap at 12
        tbl.push_back(v(1, 0, 2'b00, 0, 0, 0,  1,  0, 0, 0, 12, 0)); // shadow keeps 12
        tbl.push_back(v(1, 1, 2'b00, 0, 0, 0,  1,  0, 1, 0, 12, 0));
        tbl.push_back(v(1, 0, 2'b11, 0, 0, 0,  7,  7, 1, 0, 12, 0));
        tbl.push_back(v(0, 0, 2'b11, 0, 0, 0,  1,  0, 0, 0,  0, 0)); // reset mid-run
        tbl.push_back(v(1, 1, 2'b00, 0, 0, 0,  1,  0, 1, 0,  0, 0));
        tbl.push_back(v(1, 0, 2'b00, 0, 0, 0,  3,  3, 1, 0,  0, 0));

        @(negedge clk);
        foreach (tbl[i]) begin
            m_rst = tbl[i].rst; m_start = tbl[i].start; m_evt = tbl[i].evt;
            m_clr = tbl[i].clr; m_snap = tbl[i].snap; m_sel = tbl[i].sel;
            t_edges(tbl[i].n);
            chk($sformatf("row%0d", i),
                128'({m_cycle, m_run, m_done, m_rd, m_ovf}),
                128'({tbl[i].cyc, tbl[i].run, tbl[i].done, tbl[i].rd, tbl[i].ovf}));
        end

        // 4-bit overflow: 20 run edges with evt0 held high
        t_rst = 1'b0;
        t_edges(1);
        chk("ovf_reset", 128'({s_ovf, w_ovf, s_cycle, w_cycle}), 128'(0));
        t_rst = 1'b1; t_start = 1'b1;
        t_edges(1);
        t_start = 1'b0; t_evt = 2'b01;
        t_edges(20);
        chk("sat_live",  128'({s_cycle, s_ovf, s_run}), 128'({4'd15, 3'b011, 1'b1}));
        chk("wrap_live", 128'({w_cycle, w_ovf, w_run}), 128'({4'd4,  3'b011, 1'b1}));
        t_evt = 2'b00; t_snap = 1'b1;
        t_edges(1);
        t_snap = 1'b0; t_sel = 2'd1;
        t_edges(1);
        chk("sat_evt0",  128'(s_rd), 128'(15));
        chk("wrap_evt0", 128'(w_rd), 128'(4));
        t_sel = 2'd2;
        t_edges(1);
        chk("evt1_zero", 128'({s_rd, w_rd}), 128'(0));
        t_clr = 1'b1;
        t_edges(1);
        t_clr = 1'b0;
        chk("ovf_clr", 128'({s_ovf, w_ovf, s_cycle, w_cycle, s_run, w_run}), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
